// File: rtl/nes_controller_emulator_if.sv
// Received-word bus from network_stack_rx (axiov/axiod side) into the controller emulator.
interface nes_controller_emulator_if;
  logic        axiiv;
  logic [15:0] axiid;

  modport master (output axiiv, output axiid);
  modport slave  (input  axiiv, input  axiid);
endinterface

// File: rtl/nes_controller_emulator.sv
// NES controller (4021) emulator: network button words in, console latch/pulse/data out.
// Optional turbo on A/B enabled by defining TURBO_EN.
module nes_controller_emulator #(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned SYNC_STAGES    = 2
`ifdef TURBO_EN
  , parameter int unsigned TURBO_PERIOD = 4
`endif
) (
  input  logic                          clk,
  input  logic                          rst,
  nes_controller_emulator_if.slave      rx,
  input  logic                          latch_in,
  input  logic                          pulse_in,
  output logic                          data_out,
  output logic [7:0]                    buttons_held,
  output logic [15:0]                   latch_count,
  output logic [7:0]                    rx_err_count,
  output logic                          link_ok
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] latch_sync_q, latch_sync_d;
  logic [SYNC_STAGES-1:0] pulse_sync_q, pulse_sync_d;
  logic                   latch_prev_q, latch_prev_d;
  logic                   pulse_prev_q, pulse_prev_d;
  logic                   latch_s, pulse_s, latch_rise, pulse_rise;
  logic [7:0]             sr_q, sr_d, load_val;
  logic                   data_q, data_d;
  logic [7:0]             buttons_q, buttons_d;
  logic [15:0]            latch_cnt_q, latch_cnt_d;
  logic [7:0]             err_q, err_d;
  logic                   link_q, link_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic                   accept;

  // Synchronizers and rising-edge strobes for the console lines
  always_comb begin
    latch_sync_d = {latch_sync_q[SYNC_STAGES-2:0], latch_in};
    pulse_sync_d = {pulse_sync_q[SYNC_STAGES-2:0], pulse_in};
    latch_s      = latch_sync_q[SYNC_STAGES-1];
    pulse_s      = pulse_sync_q[SYNC_STAGES-1];
    latch_prev_d = latch_s;
    pulse_prev_d = pulse_s;
    latch_rise   = latch_s & ~latch_prev_q;
    pulse_rise   = pulse_s & ~pulse_prev_q;
  end

  // Word acceptance, error counting and link timeout
  always_comb begin
    buttons_d = buttons_q;
    link_d    = link_q;
    tmo_d     = tmo_q;
    err_d     = err_q;
    accept    = rx.axiiv && (rx.axiid[15:8] == rx.axiid[7:0]);
    if (accept) begin
      buttons_d = rx.axiid[7:0];
      link_d    = 1'b1;
      tmo_d     = '0;
    end else begin
      if (rx.axiiv && (err_q != 8'hFF)) begin
        err_d = err_q + 8'd1;
      end
      if (tmo_q != TMO_MAX) begin
        tmo_d = tmo_q + 1'b1;
      end
      if (tmo_d == TMO_MAX) begin
        buttons_d = '0;
        link_d    = 1'b0;
      end
    end
  end

  always_comb begin
    latch_cnt_d = latch_cnt_q;
    if (latch_rise) begin
      latch_cnt_d = latch_cnt_q + 16'd1;
    end
  end

`ifdef TURBO_EN
  localparam int unsigned TCNT_W = (TURBO_PERIOD > 1) ? $clog2(TURBO_PERIOD) : 1;

  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic              phase_q, phase_d;

  // Phase advances as each frame leaves LOAD, so the frame being loaded
  // always sees the phase that belongs to it.
  always_comb begin
    tcnt_d  = tcnt_q;
    phase_d = phase_q;
    if ((state_q == LOAD) && !latch_s) begin
      if (tcnt_q == TCNT_W'(TURBO_PERIOD - 1)) begin
        tcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        tcnt_d = tcnt_q + 1'b1;
      end
    end
    load_val = {buttons_q[7:6] & {2{phase_q}}, buttons_q[5:0]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcnt_q  <= '0;
      phase_q <= 1'b1;
    end else begin
      tcnt_q  <= tcnt_d;
      phase_q <= phase_d;
    end
  end
`else
  always_comb begin
    load_val = buttons_q;
  end
`endif

  // Shift-register FSM; latch rise takes priority over a coincident pulse rise
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        data_d = 1'b1;
        if (latch_rise) begin
          state_d = LOAD;
          sr_d    = load_val;
          data_d  = ~load_val[7];
        end
      end
      LOAD: begin
        if (latch_s) begin
          sr_d   = load_val;
          data_d = ~load_val[7];
        end else begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (latch_rise) begin
          state_d = LOAD;
          sr_d    = load_val;
          data_d  = ~load_val[7];
        end else if (pulse_rise) begin
          sr_d   = {sr_q[6:0], 1'b0};
          data_d = ~sr_q[6];
        end
      end
      default: begin
        state_d = IDLE;
        data_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      latch_sync_q <= '0;
      pulse_sync_q <= '0;
      latch_prev_q <= 1'b0;
      pulse_prev_q <= 1'b0;
      sr_q         <= '0;
      data_q       <= 1'b1;
      buttons_q    <= '0;
      latch_cnt_q  <= '0;
      err_q        <= '0;
      link_q       <= 1'b0;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      latch_sync_q <= latch_sync_d;
      pulse_sync_q <= pulse_sync_d;
      latch_prev_q <= latch_prev_d;
      pulse_prev_q <= pulse_prev_d;
      sr_q         <= sr_d;
      data_q       <= data_d;
      buttons_q    <= buttons_d;
      latch_cnt_q  <= latch_cnt_d;
      err_q        <= err_d;
      link_q       <= link_d;
      tmo_q        <= tmo_d;
    end
  end

  always_comb begin
    data_out     = data_q;
    buttons_held = buttons_q;
    latch_count  = latch_cnt_q;
    rx_err_count = err_q;
    link_ok      = link_q;
  end

endmodule

// File: tb/tb_nes_controller_emulator.sv
// Scoreboard bench for nes_controller_emulator against a frame-level console/network model.
module tb_nes_controller_emulator;
  localparam int unsigned TMO  = 100;
  localparam int unsigned SYNC = 2;
  localparam int          W    = SYNC + 5;
`ifdef TURBO_EN
  localparam int          TP   = 2;
`endif

  typedef enum int {K_DATA, K_HELD, K_ERR, K_LCNT, K_LINK} kind_e;
  typedef struct {
    kind_e       kind;
    logic [15:0] val;
    int          tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        latch_in, pulse_in, data_out, link_ok;
  logic [7:0]  buttons_held, rx_err_count;
  logic [15:0] latch_count;

  nes_controller_emulator_if rx_if ();

  always #10 clk = ~clk;

  nes_controller_emulator #(
    .TIMEOUT_CYCLES(TMO),
    .SYNC_STAGES(SYNC)
`ifdef TURBO_EN
    , .TURBO_PERIOD(TP)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx_if),
    .latch_in(latch_in),
    .pulse_in(pulse_in),
    .data_out(data_out),
    .buttons_held(buttons_held),
    .latch_count(latch_count),
    .rx_err_count(rx_err_count),
    .link_ok(link_ok)
  );

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          tag_n   = 0;
  int unsigned cyc      = 0;
  int unsigned last_acc = 0;
  bit          any_acc  = 1'b0;
  logic [7:0]  m_buttons = 8'h00;
  logic [7:0]  snap      = 8'h00;
  int          m_err  = 0;
  int          m_lcnt = 0;
  int          m_pidx = 0;

  // ---------------- reference model ----------------
  function automatic logic [7:0] held_now();
    if (!any_acc || (cyc - last_acc >= TMO)) return 8'h00;
    return m_buttons;
  endfunction

  function automatic bit link_now();
    return any_acc && (cyc - last_acc < TMO);
  endfunction

  function automatic logic [7:0] frame_val();
    logic [7:0] v;
    v = held_now();
`ifdef TURBO_EN
    if ((((m_lcnt - 1) / TP) % 2) == 1) v[7:6] = 2'b00;
`endif
    return v;
  endfunction

  function automatic string kname(kind_e k);
    case (k)
      K_DATA:  return "data_out";
      K_HELD:  return "buttons_held";
      K_ERR:   return "rx_err_count";
      K_LCNT:  return "latch_count";
      default: return "link_ok";
    endcase
  endfunction

  task automatic expect_val(kind_e k, logic [15:0] v);
    exp_t e;
    e.kind = k;
    e.val  = v;
    e.tag  = tag_n;
    tag_n++;
    sb.push_back(e);
  endtask

  task automatic expect_status();
    expect_val(K_HELD, {8'h00, held_now()});
    expect_val(K_ERR,  {8'h00, m_err[7:0]});
    expect_val(K_LCNT, m_lcnt[15:0]);
    expect_val(K_LINK, {15'h0000, link_now()});
  endtask

  task automatic expect_data();
    logic b;
    b = (m_pidx < 8) ? ~snap[7 - m_pidx] : 1'b1;
    expect_val(K_DATA, {15'h0000, b});
  endtask

  // ---------------- stimulus primitives ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_n(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(logic [15:0] w);
    rx_if.axiiv = 1'b1;
    rx_if.axiid = w;
    tick();
    if (w[15:8] == w[7:0]) begin
      m_buttons = w[7:0];
      any_acc   = 1'b1;
      last_acc  = cyc;
    end else if (m_err < 255) begin
      m_err++;
    end
    rx_if.axiiv = 1'b0;
  endtask

  function automatic logic [15:0] rand_good();
    logic [7:0] b;
    b = 8'($urandom);
    return {b, b};
  endfunction

  function automatic logic [15:0] rand_bad();
    logic [7:0] b;
    logic [7:0] x;
    b = 8'($urandom);
    x = 8'($urandom_range(1, 255));
    return {b ^ x, b};
  endfunction

  task automatic latch_frame();
    latch_in = 1'b1;
    m_lcnt++;
    wait_n(W);
    latch_in = 1'b0;
    snap     = frame_val();
    m_pidx   = 0;
    wait_n(W);
    expect_data();
  endtask

  task automatic pulse();
    pulse_in = 1'b1;
    wait_n(W);
    pulse_in = 1'b0;
    wait_n(W);
    m_pidx++;
    expect_data();
  endtask

  task automatic pulses(int n);
    for (int i = 0; i < n; i++) pulse();
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t        e;
    logic [15:0] act;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        case (e.kind)
          K_DATA:  act = {15'h0000, data_out};
          K_HELD:  act = {8'h00, buttons_held};
          K_ERR:   act = {8'h00, rx_err_count};
          K_LCNT:  act = latch_count;
          default: act = {15'h0000, link_ok};
        endcase
        n_tests++;
        if (act !== e.val) begin
          n_fail++;
          $display("FAIL %s #%0d at cycle %0d: got %h expected %h",
                   kname(e.kind), e.tag, cyc, act, e.val);
        end
      end
    end
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [7:0] fv;
    rst = 1'b0;
    latch_in = 1'b0;
    pulse_in = 1'b0;
    rx_if.axiiv = 1'b0;
    rx_if.axiid = 16'h0000;
    wait_n(3);
    expect_val(K_DATA, 16'h0001);
    expect_status();
    wait_n(1);
    rst = 1'b1;
    wait_n(2);
    expect_val(K_DATA, 16'h0001);

    // A and Right pressed, then past the end of the frame
    send(16'h8181);
    expect_status();
    latch_frame();
    pulses(9);
    expect_status();

    // mismatched halves, then saturation of the error count
    send(16'h8181);
    send(16'h80FF);
    expect_status();
    for (int i = 0; i < 300; i++) send(rand_bad());
    expect_status();

    // update mid-frame leaves the running frame untouched
    send(16'h4242);
    latch_frame();
    pulses(3);
    send(16'hFFFF);
    expect_status();
    pulses(5);
    latch_frame();
    pulses(8);
    expect_status();

    // update while latch is held is captured
    latch_in = 1'b1;
    m_lcnt++;
    wait_n(W);
    send(16'h2424);
    wait_n(W);
    latch_in = 1'b0;
    snap     = frame_val();
    m_pidx   = 0;
    wait_n(W);
    expect_data();
    pulses(8);

    // coincident latch and pulse: latch wins; pulses during latch ignored
    send(16'h8383);
    latch_frame();
    pulses(2);
    latch_in = 1'b1;
    pulse_in = 1'b1;
    m_lcnt++;
    wait_n(W);
    fv = frame_val();
    expect_val(K_DATA, {15'h0000, ~fv[7]});
    pulse_in = 1'b0;
    wait_n(W);
    pulse_in = 1'b1;
    wait_n(W);
    pulse_in = 1'b0;
    wait_n(W);
    fv = frame_val();
    expect_val(K_DATA, {15'h0000, ~fv[7]});
    expect_status();
    latch_in = 1'b0;
    snap     = frame_val();
    m_pidx   = 0;
    wait_n(W);
    expect_data();
    pulses(8);

    // timeout boundary
    send(16'h1010);
    while (cyc - last_acc < TMO - 1) tick();
    expect_status();
    tick();
    expect_status();
    wait_n(5);
    expect_status();
    latch_frame();
    pulses(8);

    // randomized frames with restarts and mid-frame traffic
    for (int f = 0; f < 40; f++) begin
      send(rand_good());
      latch_frame();
      for (int p = 0; p < int'($urandom_range(0, 10)); p++) begin
        pulse();
        if ($urandom_range(0, 3) == 0) begin
          if ($urandom_range(0, 1) == 0) send(rand_good());
          else send(rand_bad());
        end
      end
      expect_status();
    end

    wait_n(4);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nes_controller_emulator.md
Name: nes_controller_emulator

Overview:
- Console-side counterpart of the remote controller reader: takes button words from the UDP receive stack and presents them to a real NES console.
- Emulates the controller's 4021 shift register, responding to the console's latch/pulse lines on the data line.
- Sits between network_stack_rx (axiov/axiod) and the console controller port.
- Runs on the 50 MHz eth_refclk domain.

Parameters:
- TIMEOUT_CYCLES, 50_000_000: cycles with no valid update before held buttons are cleared (1 s at 50 MHz).
- SYNC_STAGES, 2: flip-flop depth of the latch/pulse input synchronizers (allowed 2..4).
- TURBO_PERIOD, 4: console latches per turbo half-period (used only with TURBO_EN).

Ports:
- clk  in  1  system clock (eth_refclk, 50 MHz).
- rst  in  1  asynchronous, active-low reset.
- axiiv  in  1  received word valid, from network_stack_rx.
- axiid  in  16  received word, formatted {buttons,buttons}, 1 = pressed; bit7 = A, 6 = B, 5 = Select, 4 = Start, 3 = Up, 2 = Down, 1 = Left, 0 = Right.
- latch_in  in  1  console latch, asynchronous to clk.
- pulse_in  in  1  console clock pulse, asynchronous to clk.
- data_out  out  1  console data line, active-low (0 = pressed).
- buttons_held  out  8  current held button state, for LEDs.
- latch_count  out  16  number of console latch rising edges, wraps at 16 bits.
- rx_err_count  out  8  rejected words, saturates at 255.
- link_ok  out  1  high while the timeout has not expired.

Behaviour:
- Reset (rst = 0, async) clears internal state and sets outputs:
  - data_out = 1; buttons_held = 0; latch_count = 0; rx_err_count = 0; link_ok = 0.
  - Shift register = 0; timeout counter = 0; synchronizers = 0.
- Update path:
  - On axiiv = 1 with axiid[15:8] == axiid[7:0]: buttons_held <= axiid[7:0] next cycle, timeout counter <= 0, link_ok <= 1.
  - On axiiv = 1 with mismatched halves: word is dropped and rx_err_count increments (saturating).
  - Multi-cycle valid bursts: every valid cycle is evaluated independently.
- Timeout:
  - Counter increments every cycle without an accepted word, saturating at TIMEOUT_CYCLES.
  - On reaching TIMEOUT_CYCLES: buttons_held <= 0 and link_ok <= 0, in the same cycle.
  - An accepted word in the expiry cycle wins.
- Input conditioning:
  - latch_in and pulse_in each pass through SYNC_STAGES flip-flops plus one edge-detect register.
  - Rising-edge strobes are single-cycle, SYNC_STAGES+1 cycles after the pin edge.
- FSM states: IDLE, LOAD, SHIFT.
  - IDLE: data_out = 1. A synced latch rise goes to LOAD and increments latch_count.
  - LOAD: active while synced latch is high.
    - Shift register reloads from buttons_held every cycle, so an update landing during the latch is captured.
    - data_out = ~sr[7].
    - pulse edges are ignored.
    - Synced latch fall goes to SHIFT.
  - SHIFT: each synced pulse rise shifts sr left and fills 0; data_out = ~sr[7] the following cycle.
    - After 8 pulses data_out stays 1; extra pulses keep shifting zeros.
    - A new latch rise goes to LOAD (restart mid-frame is legal).
- data_out is registered.
  - Latch-to-first-bit latency: SYNC_STAGES+2 cycles after the pin edge.
  - Pulse-to-next-bit latency: same.
- Button updates during SHIFT never disturb the frame in progress; they take effect at the next latch.
- Simultaneous latch rise and pulse rise in one cycle: latch wins, pulse is dropped.

Optional Feature:
- Macro TURBO_EN.
- Defined:
  - A mod-TURBO_PERIOD latch counter toggles a turbo phase bit.
  - The loaded value of bits 7 and 6 (A, B) is ANDed with the phase; phase resets to 1.
  - Held A produces press/release alternating every TURBO_PERIOD frames.
  - buttons_held still shows raw state.
- Undefined: no turbo logic; loaded value = buttons_held exactly.

Test Plan:
- Reset, then send axiid = 16'h8181: latch, then 8 pulses → data_out sequence 0,1,1,1,1,1,1,0; 9th pulse → 1; latch_count = 1.
- Send 16'h80FF → rx_err_count = 1, buttons_held unchanged; 300 more mismatches → rx_err_count = 255.
- Send 16'hFFFF mid-SHIFT after 3 pulses → remaining 5 bits follow the old value; next frame all 0.
- Send 16'h1010, then no traffic; bench with TIMEOUT_CYCLES = 100 → at cycle 100 buttons_held = 0, link_ok = 0, next frame all 1.
- Latch and pulse rising in the same synced cycle → state LOAD, no shift, first bit = ~buttons_held[7].
- TURBO_EN, TURBO_PERIOD = 2, buttons 16'h8080 held → A bit per frame: pressed, pressed, released, released, pressed...
